// File: rtl/trap_cause_arbiter.sv
// Trap cause arbiter: merges pipeline exceptions with level/edge interrupt sources
// into a single registered trap offer using a valid/ready handshake.
module trap_cause_arbiter #(
   parameter int                    XLEN      = 64,
   parameter int                    NUM_LOCAL = 16,
   parameter logic [16+NUM_LOCAL-1:0] EDGE_MASK = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [16+NUM_LOCAL-1:0] irq_i,
   input  logic [16+NUM_LOCAL-1:0] mie_i,
   input  logic                    gie_i,
   input  logic [16+NUM_LOCAL-1:0] clr_i,
   input  logic                    exc_valid_i,
   input  logic [4:0]              exc_code_i,
   input  logic [XLEN-1:0]         exc_tval_i,
   output logic                    trap_valid_o,
   input  logic                    trap_ready_i,
   output logic [XLEN-1:0]         trap_cause_o,
   output logic [XLEN-1:0]         trap_tval_o,
   output logic [16+NUM_LOCAL-1:0] mip_o
);

   localparam int NW = 16 + NUM_LOCAL;
   localparam int CW = ($clog2(NW) > 5) ? $clog2(NW) : 5;
   // Standard sources 1,3,5,7,9,11,13 plus every platform local line.
   localparam logic [NW-1:0] REAL_MASK = {{NUM_LOCAL{1'b1}}, 16'h2AAA};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   function automatic logic [XLEN-1:0] make_cause(input logic is_irq, input logic [CW-1:0] code);
      logic [XLEN-1:0] c;
      c           = '0;
      c[CW-1:0]   = code;
      c[XLEN-1]   = is_irq;
      return c;
   endfunction

   state_t          state_r;
   logic [NW-1:0]   irq_q_r;
   logic [NW-1:0]   irq_prev_r;
   logic [NW-1:0]   pend_r;
   logic            cap_irq_r;
   logic [CW-1:0]   cap_code_r;

   logic [NW-1:0]   cap_hot_s;
   logic [NW-1:0]   clr_s;
   logic [NW-1:0]   edge_set_s;
   logic [NW-1:0]   pend_next_s;
   logic [NW-1:0]   cand_s;
   logic [CW-1:0]   top_code_s;
   logic            accept_s;
   logic            cap_live_s;

   assign mip_o = pend_r;

   // Pending-bit update: edge sets beat clears, level bits track irq_q.
   always_comb begin
      cap_hot_s = '0;
      for (int i = 0; i < NW; i++) begin
         cap_hot_s[i] = (cap_code_r == CW'(i));
      end
      accept_s    = (state_r == OFFER) && trap_ready_i;
      clr_s       = clr_i | (cap_hot_s & {NW{accept_s && cap_irq_r}});
      edge_set_s  = irq_q_r & ~irq_prev_r;
      pend_next_s = REAL_MASK & ((EDGE_MASK & (edge_set_s | (pend_r & ~clr_s)))
                                 | (~EDGE_MASK & irq_q_r));
      cand_s      = pend_r & mie_i & {NW{gie_i}};
      cap_live_s  = |(cand_s & cap_hot_s);
   end

   // Priority pick: later assignments override, so the highest priority goes last.
   always_comb begin
      top_code_s = '0;
      top_code_s = cand_s[13] ? CW'(5'd13) : top_code_s;
      top_code_s = cand_s[5]  ? CW'(5'd5)  : top_code_s;
      top_code_s = cand_s[1]  ? CW'(5'd1)  : top_code_s;
      top_code_s = cand_s[9]  ? CW'(5'd9)  : top_code_s;
      top_code_s = cand_s[7]  ? CW'(5'd7)  : top_code_s;
      top_code_s = cand_s[3]  ? CW'(5'd3)  : top_code_s;
      top_code_s = cand_s[11] ? CW'(5'd11) : top_code_s;
      for (int i = 16; i < NW; i++) begin
         top_code_s = cand_s[i] ? CW'(i) : top_code_s;
      end
   end

   // Interrupt input synchronisation and pending state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q_r    <= '0;
         irq_prev_r <= '0;
         pend_r     <= '0;
      end else begin
         irq_q_r    <= irq_i;
         irq_prev_r <= irq_q_r;
         pend_r     <= pend_next_s;
      end
   end

   // Offer FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cap_irq_r    <= 1'b0;
         cap_code_r   <= '0;
         trap_valid_o <= 1'b0;
         trap_cause_o <= '0;
         trap_tval_o  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (exc_valid_i) begin
                  state_r      <= OFFER;
                  cap_irq_r    <= 1'b0;
                  cap_code_r   <= CW'(exc_code_i);
                  trap_valid_o <= 1'b1;
                  trap_cause_o <= make_cause(1'b0, CW'(exc_code_i));
                  trap_tval_o  <= exc_tval_i;
               end else if (|cand_s) begin
                  state_r      <= OFFER;
                  cap_irq_r    <= 1'b1;
                  cap_code_r   <= top_code_s;
                  trap_valid_o <= 1'b1;
                  trap_cause_o <= make_cause(1'b1, top_code_s);
                  trap_tval_o  <= '0;
               end else begin
                  state_r      <= IDLE;
                  trap_valid_o <= 1'b0;
               end
            end
            OFFER: begin
               if (trap_ready_i) begin
                  state_r      <= IDLE;
                  trap_valid_o <= 1'b0;
               end else if (cap_irq_r && exc_valid_i) begin
                  // An unaccepted interrupt offer yields to the exception.
                  cap_irq_r    <= 1'b0;
                  cap_code_r   <= CW'(exc_code_i);
                  trap_cause_o <= make_cause(1'b0, CW'(exc_code_i));
                  trap_tval_o  <= exc_tval_i;
               end else if (cap_irq_r && !cap_live_s) begin
                  state_r      <= IDLE;
                  trap_valid_o <= 1'b0;
               end else begin
                  state_r      <= OFFER;
                  trap_valid_o <= 1'b1;
               end
            end
            default: begin
               state_r      <= IDLE;
               trap_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_cause_arbiter.sv
// Directed testbench for trap_cause_arbiter with hand-computed expectations.
module tb_trap_cause_arbiter;

   localparam int NW = 32;
   localparam logic [63:0] IRQ = 64'h8000_0000_0000_0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NW-1:0] irq_i, mie_i, clr_i, mip_o;
   logic          gie_i, exc_valid_i, trap_valid_o, trap_ready_i;
   logic [4:0]    exc_code_i;
   logic [63:0]   exc_tval_i, trap_cause_o, trap_tval_o;

   int n_checks = 0;
   int n_pass   = 0;

   trap_cause_arbiter #(
      .XLEN(64), .NUM_LOCAL(16), .EDGE_MASK(32'h0010_0000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .mie_i(mie_i), .gie_i(gie_i),
      .clr_i(clr_i), .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i),
      .exc_tval_i(exc_tval_i), .trap_valid_o(trap_valid_o), .trap_ready_i(trap_ready_i),
      .trap_cause_o(trap_cause_o), .trap_tval_o(trap_tval_o), .mip_o(mip_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Return to IDLE with no pending interrupts, restoring full enables.
   task automatic quiesce();
      mie_i = '0; irq_i = '0; clr_i = '0; trap_ready_i = 1'b0; exc_valid_i = 1'b0;
      tick(4);
      mie_i = '1; gie_i = 1'b1;
      tick(1);
   endtask

   initial begin
      rst_n = 1'b0; irq_i = '0; mie_i = '1; gie_i = 1'b1; clr_i = '0;
      exc_valid_i = 1'b0; exc_code_i = '0; exc_tval_i = '0; trap_ready_i = 1'b0;
      tick(2);
      check("rst_valid", {63'd0, trap_valid_o}, 64'd0);
      check("rst_cause", trap_cause_o, 64'd0);
      check("rst_mip", {32'd0, mip_o}, 64'd0);
      rst_n = 1'b1;
      tick(1);

      // Exception held while ready is low, then accepted.
      exc_valid_i = 1'b1; exc_code_i = 5'd2; exc_tval_i = 64'hDEAD;
      for (int c = 0; c < 3; c++) begin
         tick(1);
         check("exc_valid", {63'd0, trap_valid_o}, 64'd1);
         check("exc_cause", trap_cause_o, 64'h2);
         check("exc_tval", trap_tval_o, 64'hDEAD);
      end
      trap_ready_i = 1'b1;
      tick(1);
      exc_valid_i = 1'b0; trap_ready_i = 1'b0;
      check("exc_done", {63'd0, trap_valid_o}, 64'd0);
      tick(1);
      check("exc_idle", {63'd0, trap_valid_o}, 64'd0);

      // MEI and MTI rise together: MEI wins, MTI follows.
      irq_i = 32'h0000_0880;
      tick(1);
      check("lat_mip_n1", {32'd0, mip_o}, 64'd0);
      tick(1);
      check("lat_mip_n2", {32'd0, mip_o}, 64'h880);
      check("lat_valid_n2", {63'd0, trap_valid_o}, 64'd0);
      tick(1);
      check("mei_valid", {63'd0, trap_valid_o}, 64'd1);
      check("mei_cause", trap_cause_o, IRQ | 64'hB);
      check("mei_tval", trap_tval_o, 64'd0);
      trap_ready_i = 1'b1; mie_i[11] = 1'b0;
      tick(1);
      trap_ready_i = 1'b0;
      check("gap_after_acc", {63'd0, trap_valid_o}, 64'd0);
      tick(1);
      check("mti_cause", trap_cause_o, IRQ | 64'h7);
      check("mti_valid", {63'd0, trap_valid_o}, 64'd1);
      quiesce();

      // Edge source 20: pulse latches, acceptance clears.
      irq_i[20] = 1'b1;
      tick(1);
      irq_i[20] = 1'b0;
      tick(1);
      check("edge_set", {32'd0, mip_o}, 64'h0010_0000);
      tick(1);
      check("edge_cause", trap_cause_o, IRQ | 64'h14);
      tick(2);
      check("edge_held", {32'd0, mip_o}, 64'h0010_0000);
      trap_ready_i = 1'b1;
      tick(1);
      trap_ready_i = 1'b0;
      check("edge_acc_clr", {32'd0, mip_o}, 64'd0);
      mie_i[20] = 1'b0;
      irq_i[20] = 1'b1;
      tick(1);
      irq_i[20] = 1'b0; clr_i[20] = 1'b1;
      tick(1);
      clr_i[20] = 1'b0;
      check("edge_set_wins", {32'd0, mip_o}, 64'h0010_0000);
      clr_i[20] = 1'b1;
      tick(1);
      clr_i[20] = 1'b0;
      check("edge_sw_clr", {32'd0, mip_o}, 64'd0);
      quiesce();

      // MTI offer revoked by an exception.
      irq_i[7] = 1'b1;
      tick(3);
      check("mti2_cause", trap_cause_o, IRQ | 64'h7);
      exc_valid_i = 1'b1; exc_code_i = 5'd5; exc_tval_i = 64'h1234;
      tick(1);
      check("revoke_cause", trap_cause_o, 64'h5);
      check("revoke_tval", trap_tval_o, 64'h1234);
      check("revoke_valid", {63'd0, trap_valid_o}, 64'd1);
      check("revoke_mip7", {63'd0, mip_o[7]}, 64'd1);
      trap_ready_i = 1'b1;
      tick(1);
      exc_valid_i = 1'b0; trap_ready_i = 1'b0;
      quiesce();

      // Level MEI withdrawn before acceptance drops the offer.
      irq_i[11] = 1'b1;
      tick(3);
      check("mei2_cause", trap_cause_o, IRQ | 64'hB);
      irq_i[11] = 1'b0;
      tick(2);
      check("withdraw_still", {63'd0, trap_valid_o}, 64'd1);
      tick(1);
      check("withdraw_drop", {63'd0, trap_valid_o}, 64'd0);
      gie_i = 1'b0; irq_i = 32'h0000_0888;
      tick(4);
      check("gie_off_valid", {63'd0, trap_valid_o}, 64'd0);
      check("gie_off_mip", {32'd0, mip_o}, 64'h888);
      quiesce();

      // Non-source bits never pend.
      irq_i = 32'h0000_8005;
      tick(4);
      check("nonsrc_mip", {32'd0, mip_o}, 64'd0);
      check("nonsrc_valid", {63'd0, trap_valid_o}, 64'd0);
      quiesce();

      // Locals outrank MEI, highest code first.
      irq_i = 32'h8001_0800;
      tick(3);
      check("local_prio", trap_cause_o, IRQ | 64'h1F);
      quiesce();

      // Asynchronous reset mid-offer, then MSI re-pends from the held line.
      irq_i[3] = 1'b1;
      tick(3);
      check("msi_cause", trap_cause_o, IRQ | 64'h3);
      rst_n = 1'b0;
      #1;
      check("arst_valid", {63'd0, trap_valid_o}, 64'd0);
      check("arst_cause", trap_cause_o, 64'd0);
      check("arst_mip", {32'd0, mip_o}, 64'd0);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      check("rearm_n2", {63'd0, trap_valid_o}, 64'd0);
      tick(1);
      check("rearm_valid", {63'd0, trap_valid_o}, 64'd1);
      check("rearm_cause", trap_cause_o, IRQ | 64'h3);
      quiesce();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/trap_cause_arbiter.md
TRAP_CAUSE_ARBITER -- requirements
Module: trap_cause_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64: width of the cause and tval outputs.
REQ-002 SHALL have parameter NUM_LOCAL, default 16: platform local interrupts, codes 16..16+NUM_LOCAL-1; NW = 16+NUM_LOCAL.
REQ-003 SHALL have parameter EDGE_MASK [NW-1:0], default 0: bit i = 1 makes source i edge-triggered, 0 makes it level-sensitive.
REQ-004 SHALL have port clk  in  1  sole clock, all state on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port irq_i  in  NW  raw interrupt lines; bit index = interrupt code.
REQ-007 SHALL have port mie_i  in  NW  per-source enable.
REQ-008 SHALL have port gie_i  in  1  global interrupt enable.
REQ-009 SHALL have port clr_i  in  NW  software clear of edge pending bits.
REQ-010 SHALL have port exc_valid_i  in  1  pipeline exception request; held until accepted.
REQ-011 SHALL have port exc_code_i  in  5  exception code (values 0..19 of the exception code set).
REQ-012 SHALL have port exc_tval_i  in  XLEN  exception trap value.
REQ-013 SHALL have port trap_valid_o  out  1  trap offer.
REQ-014 SHALL have port trap_ready_i  in  1  trap accept.
REQ-015 SHALL have port trap_cause_o  out  XLEN  cause; bit XLEN-1 = interrupt flag, bits 4:0 = code for exceptions, code bits zero-extended for local interrupts.
REQ-016 SHALL have port trap_tval_o  out  XLEN  trap value.
REQ-017 SHALL have port mip_o  out  NW  pending view.

Function
REQ-018 SHALL treat only bits 1,3,5,7,9,11,13 and 16..NW-1 as real sources; all other bits SHALL read 0 in mip_o and never win arbitration.
REQ-019 SHALL register irq_i once into irq_q; level pending = irq_q; edge pending SHALL set when irq_q=1 and the previous irq_q=0.
REQ-020 SHALL clear edge pending bit i on clr_i[i] or on acceptance of interrupt i; a set in the same cycle SHALL win over a clear.
REQ-021 SHALL expose mip_o = pending (edge and level), one cycle after irq_q.
REQ-022 SHALL form the candidate set as mip_o & mie_i & {NW{gie_i}}.
REQ-023 SHALL use this priority: local interrupts, highest code first; then MEI(11), MSI(3), MTI(7), SEI(9), SSI(1), STI(5), COI(13).
REQ-024 SHALL give any exception priority over every interrupt.
REQ-025 SHALL implement the FSM states IDLE and OFFER.
REQ-026 IDLE: on exc_valid_i, SHALL capture the exception (flag=0, code, tval=exc_tval_i) and go to OFFER.
REQ-027 IDLE: otherwise, if the candidate set is non-zero, SHALL capture the top candidate (flag=1, tval=0) and go to OFFER.
REQ-028 OFFER: SHALL assert trap_valid_o and hold the captured cause and tval.
REQ-029 OFFER: on trap_valid_o and trap_ready_i, SHALL accept the trap and return to IDLE.
REQ-030 Throughput SHALL be at most one trap per 2 cycles.
REQ-031 An interrupt offer SHALL be revocable: in OFFER, an exc_valid_i not accepted this cycle SHALL replace the capture with the exception (trap_valid_o stays 1).
REQ-032 An interrupt offer whose bit leaves the candidate set, without acceptance, SHALL drop to IDLE (trap_valid_o=0 next cycle).
REQ-033 An exception offer SHALL be irrevocable: cause and tval stable until accepted.
REQ-034 Latency: exc_valid_i at cycle N SHALL give trap_valid_o at N+1.
REQ-035 Latency: a rising edge on irq_i sampled at cycle N SHALL give mip_o at N+2 and trap_valid_o at N+3, when enabled and IDLE.

Reset
REQ-036 While rst_n=0: state=IDLE, irq_q=0, edge pending=0, trap_valid_o=0, trap_cause_o=0, trap_tval_o=0, mip_o=0.
REQ-037 Reset mid-offer SHALL discard the offer with no pending clear; level sources SHALL re-pend from irq_i after release.

Verification
REQ-038 exc_valid_i=1, code=2, tval=0xDEAD, ready=0 for 3 cycles, then ready=1 -> trap_valid_o high from N+1; cause=0x2 and tval=0xDEAD stable throughout; valid=0 after acceptance.
REQ-039 irq_i[7] and irq_i[11] rise together, mie all 1, gie=1 -> cause=0x8000_0000_0000_000B first; MTI (…0007) offered after acceptance.
REQ-040 NUM_LOCAL=16, edge source 20 pulsed one cycle -> mip_o[20] set and held; accept -> mip_o[20]=0; a pulse coinciding with clr_i[20] -> bit stays 1.
REQ-041 MTI offered with ready=0, then exc_valid_i code=5 -> next cycle cause=0x5 with valid held high; mip_o[7] still 1.
REQ-042 Level MEI offered, irq_i[11] deasserts before ready -> trap_valid_o falls; gie_i=0 with pending 0x888 -> no offer; mip_o=0x888.
REQ-043 rst_n low during OFFER -> all outputs 0 asynchronously; after release a held irq_i[3] re-offers cause …0003 at N+3.
